// File: rtl/ginv_pkg.sv
// Shared mode encodings and the per-beat transform for the ginv inverter pipeline.
package ginv_pkg;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INV    = 2'b01;
  localparam logic [1:0] MODE_MASK   = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  // Transform is computed at a fixed maximum width; callers cast down to their WIDTH.
  localparam int GINV_MAX_W = 64;

  typedef logic [GINV_MAX_W-1:0] ginv_word_t;

  function automatic ginv_word_t ginv_xform(input ginv_word_t d,
                                            input logic [1:0] mode,
                                            input ginv_word_t mask,
                                            input logic t);
    ginv_word_t r;
    case (mode)
      MODE_PASS: r = d;
      MODE_INV:  r = ~d;
      MODE_MASK: r = d ^ mask;
      default:   r = d ^ {GINV_MAX_W{t}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ginv_stage.sv
// One valid/data register slice of the ginv pipeline with a combinational ready pass-through.
module ginv_stage
  import ginv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = ~valid | down_ready;

  // Data only loads with a real beat, so an emptied slice keeps showing its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/ginv_pipe.sv
// Pipelined WIDTH-bit inverter bank: per-beat mode transform, then STAGES handshake slices.
module ginv_pipe
  import ginv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic             t;
  logic             accept;
  logic [WIDTH-1:0] xf;

  logic [STAGES-1:0] v;
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  up_d  [STAGES];
  logic [WIDTH-1:0]  sdata [STAGES];

  assign in_ready = rst_n & rdy[0];
  assign accept   = in_valid & in_ready;

  assign xf = WIDTH'(ginv_xform(GINV_MAX_W'(in_data), mode, GINV_MAX_W'(mask), t));

  // Toggle phase advances only on accepted TOGGLE beats; any other accepted mode restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t <= 1'b0;
    end else if (accept) begin
      t <= (mode == MODE_TOGGLE) ? ~t : 1'b0;
    end
  end

  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_v[k] = in_valid;
      assign up_d[k] = xf;
    end else begin : g_body
      assign up_v[k] = v[k-1];
      assign up_d[k] = sdata[k-1];
    end

    ginv_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid  (up_v[k]),
      .up_data   (up_d[k]),
      .down_ready(rdy[k+1]),
      .valid     (v[k]),
      .data      (sdata[k]),
      .ready     (rdy[k])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = sdata[STAGES-1];
  assign busy      = |v;

endmodule

// File: tb/tb_ginv_pipe.sv
// Self-checking bench for ginv_pipe: directed scenarios plus randomized scoreboard runs.
module tb_ginv_pipe;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_data, mask, out_data;
  logic [1:0] mode;

  logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_busy;
  logic [0:0] w1_in_data, w1_mask, w1_out_data;
  logic [1:0] w1_mode;

  int n_cmp = 0;
  int n_bad = 0;

  bit         t1, t2;
  logic [7:0] pend1[$], got1[$], exp1[$];
  logic [7:0] pend2[$], got2[$], exp2[$];

  ginv_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  ginv_pipe #(.WIDTH(1), .STAGES(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
    .mode(w1_mode), .mask(w1_mask),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_data(w1_out_data),
    .busy(w1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference transform straight from the mode rules, trimmed to w bits.
  function automatic logic [7:0] ref_xform(input logic [7:0] d, input logic [1:0] m,
                                           input logic [7:0] mk, input bit t, input int w);
    logic [7:0] r;
    logic [7:0] wm;
    wm = 8'hFF >> (8 - w);
    case (m)
      2'd0:    r = d;
      2'd1:    r = ~d;
      2'd2:    r = d ^ mk;
      default: r = t ? ~d : d;
    endcase
    return r & wm;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m,
                       input logic [7:0] mk, input logic ordy);
    in_valid  = v;
    in_data   = d;
    mode      = m;
    mask      = mk;
    out_ready = ordy;
    #1;
  endtask

  task automatic drive2(input logic v, input logic d, input logic [1:0] m,
                        input logic mk, input logic ordy);
    w1_in_valid  = v;
    w1_in_data   = d;
    w1_mode      = m;
    w1_mask      = mk;
    w1_out_ready = ordy;
    #1;
  endtask

  // Records the handshakes of the coming edge into the models, then moves to the next negedge.
  task automatic adv();
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got1.push_back(out_data);
        exp1.push_back(pend1.size() != 0 ? pend1.pop_front() : 8'hxx);
      end
      if (in_valid && in_ready) begin
        pend1.push_back(ref_xform(in_data, mode, mask, t1, 8));
        t1 = (mode == 2'd3) ? ~t1 : 1'b0;
      end
      if (w1_out_valid && w1_out_ready) begin
        got2.push_back({7'd0, w1_out_data});
        exp2.push_back(pend2.size() != 0 ? pend2.pop_front() : 8'hxx);
      end
      if (w1_in_valid && w1_in_ready) begin
        pend2.push_back(ref_xform({7'd0, w1_in_data}, w1_mode, {7'd0, w1_mask}, t2, 1));
        t2 = (w1_mode == 2'd3) ? ~t2 : 1'b0;
      end
    end else begin
      pend1.delete();
      pend2.delete();
      t1 = 1'b0;
      t2 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 2'd0, 8'h00, 1'b1);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_in_ready_low: got %b want 0", in_ready);
      end
      adv();
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
    drive2(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL reset_out_data: got %h want 00", out_data);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || w1_in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_in_ready_release: got %b/%b want 1/1", in_ready, w1_in_ready);
    end
    adv();
  endtask

  task automatic test_modes();
    logic [1:0] m_tab [3];
    logic [7:0] mk_tab[3];
    logic [7:0] e_tab [3];
    m_tab  = '{2'd0, 2'd1, 2'd2};
    mk_tab = '{8'h00, 8'h00, 8'hF0};
    for (int i = 0; i < 3; i++) e_tab[i] = ref_xform(8'hA5, m_tab[i], mk_tab[i], 1'b0, 8);
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, 8'hA5, m_tab[c], mk_tab[c], 1'b1);
      else       drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
      n_cmp++;
      if (c >= 2 && c < 5) begin
        if ({out_valid, out_data} !== {1'b1, e_tab[c-2]}) begin
          n_bad++;
          $display("[TB] FAIL modes_out c=%0d: got v=%b d=%h want v=1 d=%h",
                   c, out_valid, out_data, e_tab[c-2]);
        end
      end else if (out_valid !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL modes_idle c=%0d: got v=%b want 0", c, out_valid);
      end
      adv();
    end
  endtask

  task automatic test_toggle();
    logic [1:0] m_tab[5];
    logic [7:0] e_tab[5];
    m_tab = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3};
    e_tab = '{8'h0F, 8'hF0, 8'h0F, 8'h0F, 8'h0F};
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(1'b1, 8'h0F, m_tab[c], 8'h00, 1'b1);
      else       drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
      if (c >= 2 && c < 7) begin
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, e_tab[c-2]}) begin
          n_bad++;
          $display("[TB] FAIL toggle_out c=%0d: got v=%b d=%h want v=1 d=%h",
                   c, out_valid, out_data, e_tab[c-2]);
        end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] beats[4];
    int j;
    int cyc;
    for (int i = 0; i < 4; i++) beats[i] = 8'($urandom);
    got1.delete();
    exp1.delete();
    j = 0;
    for (int c = 0; c < 6; c++) begin
      drive(j < 4, beats[j % 4], 2'd0, 8'h00, 1'b0);
      if (c >= 2) begin
        n_cmp++;
        if ({in_ready, out_valid, busy, out_data} !== {1'b0, 1'b1, 1'b1, beats[0]}) begin
          n_bad++;
          $display("[TB] FAIL bp_hold c=%0d: got rdy=%b v=%b busy=%b d=%h want 0 1 1 %h",
                   c, in_ready, out_valid, busy, out_data, beats[0]);
        end
      end
      if (in_valid && in_ready) j++;
      adv();
    end
    n_cmp++;
    if (j != 2) begin
      n_bad++;
      $display("[TB] FAIL bp_accepted: got %0d want 2", j);
    end
    drive(1'b1, beats[j], 2'd0, 8'h00, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL bp_full_flow: got rdy=%b v=%b want 1 1", in_ready, out_valid);
    end
    if (in_valid && in_ready) j++;
    adv();
    cyc = 0;
    while (got1.size() < 4 && cyc < 20) begin
      drive(j < 4, beats[j % 4], 2'd0, 8'h00, 1'b1);
      if (in_valid && in_ready) j++;
      adv();
      cyc++;
    end
    n_cmp++;
    if (got1.size() != 4) begin
      n_bad++;
      $display("[TB] FAIL bp_count: got %0d want 4", got1.size());
    end
    for (int i = 0; i < got1.size(); i++) begin
      n_cmp++;
      if (got1[i] !== exp1[i] || got1[i] !== beats[i]) begin
        n_bad++;
        $display("[TB] FAIL bp_order[%0d]: got %h want %h", i, got1[i], beats[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 8'h11, 2'd3, 8'h00, 1'b0);
    adv();
    drive(1'b1, 8'h22, 2'd3, 8'h00, 1'b0);
    adv();
    rst_n = 1'b0;
    drive(1'b1, 8'h33, 2'd3, 8'h00, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL mid_rst_in_ready: got %b want 0", in_ready);
    end
    adv();
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
    n_cmp++;
    if ({out_valid, busy, in_ready, out_data} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_bad++;
      $display("[TB] FAIL mid_rst_state: got v=%b busy=%b rdy=%b d=%h want 0 0 1 00",
               out_valid, busy, in_ready, out_data);
    end
    adv();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL mid_rst_ghost c=%0d: got v=%b d=%h want v=0", c, out_valid, out_data);
      end
      adv();
    end
    drive(1'b1, 8'h3C, 2'd3, 8'h00, 1'b1);
    adv();
    drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
    adv();
    drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
      n_bad++;
      $display("[TB] FAIL mid_rst_t_clear: got v=%b d=%h want v=1 d=3c", out_valid, out_data);
    end
    adv();
  endtask

  task automatic test_w1_inv();
    logic a_tab[4];
    logic e_tab[4];
    a_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
    e_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive2(1'b1, a_tab[c], 2'd1, 1'b0, 1'b1);
      else       drive2(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      n_cmp++;
      if (c >= 1 && c < 5) begin
        if ({w1_out_valid, w1_out_data} !== {1'b1, e_tab[c-1]}) begin
          n_bad++;
          $display("[TB] FAIL w1_inv c=%0d: got v=%b d=%b want v=1 d=%b",
                   c, w1_out_valid, w1_out_data, e_tab[c-1]);
        end
      end else if (w1_out_valid !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL w1_idle c=%0d: got v=%b want 0", c, w1_out_valid);
      end
      adv();
    end
  endtask

  task automatic test_random_w8();
    int sent;
    int cyc;
    got1.delete();
    exp1.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 300 && cyc < 3000) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0);
      if (in_valid && in_ready) sent++;
      adv();
      cyc++;
    end
    while (pend1.size() != 0 && cyc < 3200) begin
      drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b1);
      adv();
      cyc++;
    end
    n_cmp++;
    if (sent != 300 || got1.size() != 300) begin
      n_bad++;
      $display("[TB] FAIL rand8_count: got sent=%0d out=%0d want 300/300", sent, got1.size());
    end
    for (int i = 0; i < got1.size(); i++) begin
      n_cmp++;
      if (got1[i] !== exp1[i]) begin
        n_bad++;
        $display("[TB] FAIL rand8_beat[%0d]: got %h want %h", i, got1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_random_w1();
    int sent;
    int cyc;
    got2.delete();
    exp2.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 8000) begin
      drive2($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
             $urandom_range(0, 2) != 0);
      if (w1_in_valid && w1_in_ready) sent++;
      adv();
      cyc++;
    end
    while (pend2.size() != 0 && cyc < 8200) begin
      drive2(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      adv();
      cyc++;
    end
    n_cmp++;
    if (sent != 1000 || got2.size() != 1000) begin
      n_bad++;
      $display("[TB] FAIL rand1_count: got sent=%0d out=%0d want 1000/1000", sent, got2.size());
    end
    for (int i = 0; i < got2.size(); i++) begin
      n_cmp++;
      if (got2[i] !== exp2[i]) begin
        n_bad++;
        $display("[TB] FAIL rand1_beat[%0d]: got %h want %h", i, got2[i], exp2[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    t1    = 1'b0;
    t2    = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 8'h00, 1'b0);
    drive2(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_modes();
    test_toggle();
    test_backpressure();
    test_reset_midstream();
    test_w1_inv();
    test_random_w8();
    test_random_w1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
